// File: rtl/vga_pkg.sv
// Shared VGA constants, pattern mode encoding and colour types for the test pattern generator.
package vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int BAR_WIDTH = 80;
    localparam int NUM_BARS  = 8;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_GRADIENT = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_SOLID    = 2'd3
    } pattern_mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Fixed pattern rotation: BARS -> GRADIENT -> CHECKER -> SOLID -> BARS.
    function automatic pattern_mode_t next_mode(input pattern_mode_t m);
        pattern_mode_t n;
        case (m)
            MODE_BARS:     n = MODE_GRADIENT;
            MODE_GRADIENT: n = MODE_CHECKER;
            MODE_CHECKER:  n = MODE_SOLID;
            default:       n = MODE_BARS;
        endcase
        return n;
    endfunction

    // Bar index from column using a chain of comparators against bar edges, no divider.
    // Columns beyond the last bar edge fall into the final (black) bar.
    function automatic logic [2:0] bar_index(input logic [9:0] col);
        logic [2:0] idx;
        idx = 3'(NUM_BARS - 1);
        for (int k = NUM_BARS - 1; k >= 1; k--) begin
            if (col < 10'(k * BAR_WIDTH)) begin
                idx = 3'(k - 1);
            end
        end
        return idx;
    endfunction

    // SMPTE-like bar palette: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
            3'd1:    c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
            3'd2:    c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
            3'd3:    c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
            3'd4:    c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
            3'd5:    c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            3'd6:    c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
            default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pattern_sequencer.sv
// Pattern mode FSM with frame counter; advances one mode every FRAMES_PER_MODE frames.
module pattern_sequencer
    import vga_pkg::*;
#(
    parameter int FRAMES_PER_MODE = 120
) (
    input  logic          clk_25,
    input  logic          n_rst,
    input  logic          vsync_in,
    input  logic          freeze,
    output pattern_mode_t mode
);

    // A single-frame mode still needs a 1-bit counter; it simply wraps every frame.
    localparam int CNT_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_MODE - 1);

    logic             r_vsync_prev;
    logic [CNT_W-1:0] r_frame_cnt;
    pattern_mode_t    r_mode;

    logic             w_frame_edge;
    logic [CNT_W-1:0] w_cnt_nxt;
    pattern_mode_t    w_mode_nxt;

    // Frame boundary is the falling edge of the active-low vsync.
    assign w_frame_edge = r_vsync_prev & ~vsync_in;

    // Registered vsync sample used for edge detection; idles high like the sync itself.
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_vsync_prev <= 1'b1;
        end else begin
            r_vsync_prev <= vsync_in;
        end
    end

    // Mode and frame counter state registers.
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_mode      <= MODE_BARS;
            r_frame_cnt <= '0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_frame_cnt <= w_cnt_nxt;
        end
    end

    // Count frames only at boundaries and only when not frozen; wrap advances the mode.
    always_comb begin
        w_mode_nxt = r_mode;
        w_cnt_nxt  = r_frame_cnt;
        if (w_frame_edge && !freeze) begin
            if (r_frame_cnt == CNT_LAST) begin
                w_cnt_nxt  = '0;
                w_mode_nxt = next_mode(r_mode);
            end else begin
                w_cnt_nxt = r_frame_cnt + 1'b1;
            end
        end
    end

    assign mode = r_mode;

endmodule

// File: rtl/test_pattern_gen.sv
// VGA test pattern generator: two-stage pixel pipeline with syncs delayed to match colour.
module test_pattern_gen
    import vga_pkg::*;
#(
    parameter  int FRAMES_PER_MODE = 120,
    localparam int PIPE_LAT        = 2
) (
    input  logic       clk_25,
    input  logic       n_rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       video_on,
    input  logic [9:0] horizontal_num,
    input  logic [9:0] vertical_num,
    input  logic       freeze,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       hsync,
    output logic       vsync
);

    // The pipeline below is written for exactly two register stages.
    if (PIPE_LAT != 2) begin : g_pipe_lat_chk
        $error("test_pattern_gen pipeline is fixed at two stages");
    end

    pattern_mode_t w_mode;
    rgb_t          w_rgb;
    logic          w_unused_row;

    logic [9:0]    r_col_p1;
    logic          r_row5_p1;
    logic          r_vld_p1;
    logic          r_hs_p1;
    logic          r_vs_p1;

    rgb_t          r_rgb_p2;
    logic          r_hs_p2;
    logic          r_vs_p2;

    // Only line bit 5 matters (checker square size); remaining line bits are intentionally dropped.
    assign w_unused_row = ^{vertical_num[9:6], vertical_num[4:0]};

    pattern_sequencer #(
        .FRAMES_PER_MODE (FRAMES_PER_MODE)
    ) u_seq (
        .clk_25   (clk_25),
        .n_rst    (n_rst),
        .vsync_in (vsync_in),
        .freeze   (freeze),
        .mode     (w_mode)
    );

    // Stage 1: register coordinates, video_on and syncs.
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_col_p1  <= '0;
            r_row5_p1 <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_hs_p1   <= 1'b1;
            r_vs_p1   <= 1'b1;
        end else begin
            r_col_p1  <= horizontal_num;
            r_row5_p1 <= vertical_num[5];
            r_vld_p1  <= video_on;
            r_hs_p1   <= hsync_in;
            r_vs_p1   <= vsync_in;
        end
    end

    // Colour for the current mode from the stage-1 coordinates.
    always_comb begin
        w_rgb = '0;
        case (w_mode)
            MODE_BARS: begin
                w_rgb = bar_colour(bar_index(r_col_p1));
            end
            MODE_GRADIENT: begin
                w_rgb = '{r: r_col_p1[9:2], g: r_col_p1[9:2], b: r_col_p1[9:2]};
            end
            MODE_CHECKER: begin
                if (r_col_p1[5] ^ r_row5_p1) begin
                    w_rgb = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
                end
            end
            default: begin
                w_rgb = '{r: 8'hFF, g: 8'h00, b: 8'h00};
            end
        endcase
    end

    // Stage 2: register blanked colour and syncs onto the outputs.
    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_rgb_p2 <= '0;
            r_hs_p2  <= 1'b1;
            r_vs_p2  <= 1'b1;
        end else begin
            r_rgb_p2 <= r_vld_p1 ? w_rgb : '0;
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
        end
    end

    assign red   = r_rgb_p2.r;
    assign green = r_rgb_p2.g;
    assign blue  = r_rgb_p2.b;
    assign hsync = r_hs_p2;
    assign vsync = r_vs_p2;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Scoreboard bench for test_pattern_gen with a frame-count based reference model.
`timescale 1ns/1ps
module tb_test_pattern_gen;

    localparam int FPM = 2;

    logic       clk_25 = 1'b0;
    logic       n_rst = 1'b1;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       video_on = 1'b0;
    logic [9:0] horizontal_num = '0;
    logic [9:0] vertical_num = '0;
    logic       freeze = 1'b0;
    logic [7:0] red, green, blue;
    logic       hsync, vsync;

    test_pattern_gen #(.FRAMES_PER_MODE(FPM)) dut (
        .clk_25         (clk_25),
        .n_rst          (n_rst),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .video_on       (video_on),
        .horizontal_num (horizontal_num),
        .vertical_num   (vertical_num),
        .freeze         (freeze),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync          (hsync),
        .vsync          (vsync)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        int         due;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: number of counted frame boundaries and last vsync seen.
    int   n_frames = 0;
    bit   m_prev_vs = 1'b1;

    always @(posedge clk_25) cyc <= cyc + 1;

    function automatic int cur_mode();
        return (n_frames / FPM) % 4;
    endfunction

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic drive(input int col, input int row, input bit von, input bit hs,
                         input bit vs, input bit frz);
        exp_t       e;
        logic [23:0] c;
        logic [23:0] bars [8];
        int          m;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        @(posedge clk_25);
        #1;
        horizontal_num = 10'(col);
        vertical_num   = 10'(row);
        video_on       = von;
        hsync_in       = hs;
        vsync_in       = vs;
        freeze         = frz;
        if (m_prev_vs && !vs && !frz) n_frames++;
        m_prev_vs = vs;
        m = cur_mode();
        case (m)
            0:       c = (col / 80 < 8) ? bars[col / 80] : 24'h000000;
            1:       c = {3{8'((col / 4) % 256)}};
            2:       c = (((col / 32) % 2) != ((row / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: c = 24'hFF0000;
        endcase
        if (!von) c = 24'h000000;
        e.due = cyc + 2;
        e.r   = c[23:16];
        e.g   = c[15:8];
        e.b   = c[7:0];
        e.hs  = hs;
        e.vs  = vs;
        q.push_back(e);
    endtask

    task automatic rand_pix(input bit frz);
        int col, row;
        bit von, hs;
        col = $urandom_range(0, 799);
        row = $urandom_range(0, 524);
        von = (col < 640) && (row < 480) && ($urandom_range(0, 7) != 0);
        hs  = !((col >= 656) && (col < 752));
        drive(col, row, von, hs, 1'b1, frz);
    endtask

    // One frame: directed points, random pixels, then a two-line vsync pulse.
    task automatic frame(input int npix, input bit frz_edge);
        drive(85, 10, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(400, 100, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(32, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(32, 32, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(700, 10, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(701, 10, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < npix; i++) rand_pix(frz_edge ? 1'b1 : 1'($urandom_range(0, 1)));
        drive(10, 490, 1'b0, 1'b1, 1'b0, frz_edge);
        drive(20, 491, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        drive(30, 492, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: compare the DUT outputs against the scoreboard entry due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_25);
            if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.due != cyc || red !== e.r || green !== e.g || blue !== e.b ||
                    hsync !== e.hs || vsync !== e.vs) begin
                    errors++;
                    $display("FAIL pixel due=%0d cyc=%0d got %h %h %h hs=%b vs=%b want %h %h %h hs=%b vs=%b",
                             e.due, cyc, red, green, blue, hsync, vsync, e.r, e.g, e.b, e.hs, e.vs);
                end
            end
        end
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 20000);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #5 n_rst = 1'b0;
        repeat (3) @(posedge clk_25);
        #1;
        check1("reset_rgb", {8'h0, red, green, blue}, 32'h0);
        check1("reset_syncs", {30'h0, hsync, vsync}, 32'h3);
        @(negedge clk_25);
        n_rst = 1'b1;

        drive(85, 10, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 8; f++) frame(30, 1'b0);
        for (int f = 0; f < 5; f++) frame(30, 1'b1);
        for (int f = 0; f < FPM; f++) frame(30, 1'b0);
        for (int f = 0; f < 8 && cur_mode() != 3; f++) frame(30, 1'b0);
        check1("reached_solid", 32'(cur_mode()), 32'd3);

        for (int i = 0; i < 4; i++) drive(100 + i, 100, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk_25);
        #3;
        n_rst = 1'b0;
        #1;
        check1("midline_reset_rgb", {8'h0, red, green, blue}, 32'h0);
        check1("midline_reset_syncs", {30'h0, hsync, vsync}, 32'h3);
        q.delete();
        n_frames  = 0;
        m_prev_vs = 1'b1;
        vsync_in  = 1'b1;
        hsync_in  = 1'b1;
        video_on  = 1'b0;
        repeat (2) @(posedge clk_25);
        @(negedge clk_25);
        n_rst = 1'b1;

        drive(85, 10, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) frame(30, 1'b0);

        repeat (4) @(posedge clk_25);
        #1;
        check1("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
